// File: rtl/opcode_pkg.sv
// Shared opcode decode table for the issue queue and the downstream select decoder.
package opcode_pkg;

  localparam int OPW = 4;
  localparam int DW  = 2;

  typedef enum logic [1:0] {SEL_A, SEL_B, SEL_C, ILLEGAL} op_class_e;

  // Priority msb-first; anything the decoder has no arm for, or any unknown bit, is ILLEGAL.
  function automatic op_class_e classify(input logic [OPW-1:0] op);
    if ((^op) === 1'bx) return ILLEGAL;
    if (op[OPW-1]) return SEL_A;
    if (op[OPW-2]) return SEL_B;
    if (op[OPW-3]) return SEL_C;
    return ILLEGAL;
  endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO: the head entry sits in a register that is valid whenever level>0.
module sync_fifo_sa #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic             do_push, do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_next = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The head register is refilled from the pushed word when it becomes the only entry,
  // otherwise from the next stored entry; with nothing left it keeps its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   level <= level + ONE_LVL;
        2'b01:   level <= level - ONE_LVL;
        default: level <= level;
      endcase
      if (do_push && (empty || (level == ONE_LVL && do_pop)))
        head <= push_data;
      else if (do_pop && level > ONE_LVL)
        head <= mem[rd_next];
    end
  end

endmodule

// File: rtl/opcode_issue_queue.sv
// Issue queue in front of the opcode select decoder: drops undecodable opcodes and counts them.
module opcode_issue_queue
  import opcode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPW-1:0]           in_opcode,
  input  logic [DW-1:0]            in_a,
  input  logic [DW-1:0]            in_b,
  input  logic [DW-1:0]            in_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPW-1:0]           opcode,
  output logic [DW-1:0]            a,
  output logic [DW-1:0]            b,
  output logic [DW-1:0]            c,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_pulse,
  output logic [CNTW-1:0]          err_count
);

  localparam int WIDTH = OPW + 3*DW;

  op_class_e        in_class;
  logic             consume, push, reject, full, empty;
  logic [WIDTH-1:0] head;

  assign in_class = classify(in_opcode);
  assign in_ready = !full;
  assign consume  = in_valid && in_ready;
  assign push     = consume && (in_class != ILLEGAL);
  assign reject   = consume && (in_class == ILLEGAL);

  sync_fifo_sa #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({in_opcode, in_a, in_b, in_c}),
    .pop       (out_ready),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid         = !empty;
  assign {opcode, a, b, c} = head;

  // Rejected-opcode counter saturates at all-ones so software never sees a wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= reject;
      if (reject && err_count != '1) err_count <= err_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_opcode_issue_queue.sv
// Scoreboard bench for opcode_issue_queue: randomized and directed traffic against a queue model.
module tb_opcode_issue_queue;

  localparam int DEPTH = 4;
  localparam int CNTW  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_opcode, opcode;
  logic [1:0] in_a, in_b, in_c, a, b, c;
  logic [2:0] level;
  logic       err_pulse;
  logic [7:0] err_count;

  int tests = 0;
  int fails = 0;

  opcode_issue_queue #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .a(a), .b(b), .c(c),
    .level(level), .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: legal words are opcodes >= 2, kept in arrival order; illegal ones only count.
  logic [9:0] model_q[$];
  int         exp_err = 0;
  bit         exp_pulse = 0;
  bit         hold_valid = 0;
  logic [10:0] held;
  bit         accept, popq;

  always @(negedge clk) begin
    if (reset) begin
      model_q.delete();
      exp_err    = 0;
      exp_pulse  = 0;
      hold_valid = 0;
    end else begin
      check("level", 32'(level), 32'(model_q.size()));
      check("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
      check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      check("err_pulse", 32'(err_pulse), 32'(exp_pulse));
      check("err_count", 32'(err_count), 32'(exp_err));
      if (model_q.size() != 0) check("head", 32'({opcode, a, b, c}), 32'(model_q[0]));
      if (hold_valid) check("hold", 32'({out_valid, opcode, a, b, c}), 32'(held));
      hold_valid = out_valid && !out_ready;
      held       = {out_valid, opcode, a, b, c};
      accept     = in_valid && (model_q.size() < DEPTH);
      popq       = (model_q.size() != 0) && out_ready;
      if (popq) void'(model_q.pop_front());
      exp_pulse  = accept && (in_opcode < 4'd2);
      if (accept) begin
        if (in_opcode >= 4'd2) model_q.push_back({in_opcode, in_a, in_b, in_c});
        else if (exp_err < 255) exp_err++;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [1:0] va, input logic [1:0] vb,
                      input logic [1:0] vc);
    bit acc = 0;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a = va; in_b = vb; in_c = vc;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 0; in_opcode = 0; in_a = 0; in_b = 0; in_c = 0; out_ready = 0;
    #3;
    check("rst_level", 32'(level), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_opcode", 32'({opcode, a, b, c}), 0);
    check("rst_err", 32'({err_pulse, err_count}), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single word, downstream always ready
    out_ready = 1'b1;
    send(4'b1000, 2'd1, 2'd0, 2'd0);
    check("first_valid", 32'(out_valid), 1);
    check("first_word", 32'({opcode, a}), 32'({4'b1000, 2'd1}));
    idle(2);

    // Fill with downstream stalled, offer a fifth word, then drain
    out_ready = 1'b0;
    send(4'b0100, 2'd1, 2'd2, 2'd3);
    send(4'b0010, 2'd2, 2'd3, 2'd0);
    send(4'b1111, 2'd3, 2'd0, 2'd1);
    send(4'b0110, 2'd0, 2'd1, 2'd2);
    check("full_level", 32'(level), 4);
    in_valid = 1'b1; in_opcode = 4'b0011;
    repeat (3) @(posedge clk);
    #1;
    check("full_no_accept", 32'({level, in_ready}), 32'({3'd4, 1'b0}));
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(6);

    // Illegal opcodes, then drive the counter into saturation
    send(4'b0000, 2'd0, 2'd0, 2'd0);
    send(4'b0001, 2'd1, 2'd1, 2'd1);
    idle(2);
    check("err_two", 32'(err_count), 2);
    in_valid = 1'b1; in_opcode = 4'b0000;
    repeat (252) @(posedge clk);
    #1 in_valid = 1'b0;
    idle(2);
    check("err_254", 32'(err_count), 254);
    in_valid = 1'b1; in_opcode = 4'b0001;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    idle(2);
    check("err_sat", 32'(err_count), 255);

    // Full queue with simultaneous offer and pop: pop only, then overlap
    out_ready = 1'b0;
    send(4'b1001, 2'd1, 2'd1, 2'd1);
    send(4'b0101, 2'd2, 2'd2, 2'd2);
    send(4'b0011, 2'd3, 2'd3, 2'd3);
    send(4'b1100, 2'd0, 2'd1, 2'd3);
    in_valid = 1'b1; in_opcode = 4'b1010; in_a = 2'd2; out_ready = 1'b1;
    @(posedge clk); #1;
    check("full_pop_only", 32'(level), 3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("overlap_level", 32'(level), 3);
    idle(6);

    // Random back-to-back stream with stalls
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_opcode = 4'($urandom);
      in_a = 2'($urandom); in_b = 2'($urandom); in_c = 2'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    idle(6);

    // Asynchronous reset with three entries queued
    out_ready = 1'b0;
    send(4'b1110, 2'd1, 2'd2, 2'd3);
    send(4'b0111, 2'd3, 2'd2, 2'd1);
    send(4'b0010, 2'd0, 2'd3, 2'd0);
    check("pre_reset_level", 32'(level), 3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_level", 32'(level), 0);
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_err", 32'(err_count), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 200; i++) begin
      in_valid  = $urandom_range(0, 1);
      in_opcode = 4'($urandom);
      in_a = 2'($urandom); in_b = 2'($urandom); in_c = 2'($urandom);
      out_ready = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
